fetch_ctrl: RTL and testbench

- Sequencing controller for the IF stage.
- Drives the PC-select mux, the PC register enable, IF/ID enable/flush and the instruction-memory request.
- Tolerates variable-latency imem: holds the PC stable until imem_ready, aborts in-flight fetches on M-stage branch redirects, honours decode stalls, and traps dead memory with a timeout.
- Sits beside the fetch datapath inside the CPU datapath; inputs come from hazard/branch logic.

---
 rtl/fetch_ctrl_pkg.sv | 14 +
 rtl/fetch_ctrl_wait_timer.sv | 38 +++
 rtl/fetch_ctrl.sv | 115 +++++++++++
 tb/tb_fetch_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and encodings for the IF-stage fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    REQ   = 2'd1,
    ABORT = 2'd2,
    ERR   = 2'd3
  } fetch_state_t;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

endpackage

// File: rtl/fetch_ctrl_wait_timer.sv
// Consecutive not-ready cycle counter; saturates at TIMEOUT-1 and flags the hit.
module wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear dominates increment; holding at LAST keeps the count from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencing FSM: PC select/enable, IF/ID enable/flush and imem request,
// with redirect abort, decode-stall hold and a dead-memory timeout.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic br_taken_M,
  input  logic stall_D,
  input  logic imem_ready,
  output logic imem_req,
  output logic pc_sel,
  output logic pc_en,
  output logic ifid_en,
  output logic ifid_flush,
  output logic busy,
  output logic fetch_err
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         wait_clr;
  logic         wait_inc;
  logic         wait_hit;

  wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .hit     (wait_hit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    pc_sel     = PC_SEL_SEQ;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    busy       = 1'b0;
    fetch_err  = 1'b0;
    wait_clr   = 1'b0;
    wait_inc   = 1'b0;

    unique case (state_q)
      RST: begin
        ifid_flush = 1'b1;
        wait_clr   = 1'b1;
        state_d    = REQ;
      end

      REQ: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (br_taken_M) begin
          // M is older than D, so a redirect overrides any decode stall.
          pc_sel     = PC_SEL_BR;
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
          wait_clr   = 1'b1;
          state_d    = imem_ready ? REQ : ABORT;
        end else if (imem_ready && !stall_D) begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          wait_clr = 1'b1;
        end else if (imem_ready) begin
          wait_clr = 1'b1;
        end else begin
          wait_inc = 1'b1;
          if (wait_hit) begin
            state_d = ERR;
          end
        end
      end

      ABORT: begin
        // Request dropped for a cycle so memory discards the stale access.
        busy     = 1'b1;
        wait_clr = 1'b1;
        if (br_taken_M) begin
          pc_sel     = PC_SEL_BR;
          pc_en      = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          state_d = REQ;
        end
      end

      ERR: begin
        fetch_err  = 1'b1;
        ifid_flush = 1'b1;
      end

      default: begin
        state_d = RST;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with TIMEOUT=4: directed per-cycle vectors.
module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  logic br_taken_M;
  logic stall_D;
  logic imem_ready;
  logic imem_req;
  logic pc_sel;
  logic pc_en;
  logic ifid_en;
  logic ifid_flush;
  logic busy;
  logic fetch_err;

  always #5 clk = ~clk;

  fetch_ctrl #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .br_taken_M (br_taken_M),
    .stall_D    (stall_D),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .pc_sel     (pc_sel),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .ifid_flush (ifid_flush),
    .busy       (busy),
    .fetch_err  (fetch_err)
  );

  // Output vector order: {imem_req, pc_sel, pc_en, ifid_en, ifid_flush, busy, fetch_err}
  localparam logic [6:0] O_RST   = 7'b0000100;
  localparam logic [6:0] O_SEQ   = 7'b1011010;
  localparam logic [6:0] O_STALL = 7'b1000010;
  localparam logic [6:0] O_WAIT  = 7'b1000010;
  localparam logic [6:0] O_BR    = 7'b1110110;
  localparam logic [6:0] O_ABRT  = 7'b0000010;
  localparam logic [6:0] O_ABRB  = 7'b0110110;
  localparam logic [6:0] O_ERR   = 7'b0000101;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  // Drive one cycle of inputs; optionally queue the expected Mealy outputs.
  task automatic cyc(input logic rn, input logic br, input logic st, input logic rdy,
                     input bit chk, input logic [6:0] exp, input string name);
    sb_t e;
    @(posedge clk);
    #1;
    reset_n    = rn;
    br_taken_M = br;
    stall_D    = st;
    imem_ready = rdy;
    if (chk) begin
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
    end
  endtask

  // Monitor: pops and compares mid-cycle, after inputs have settled.
  always @(negedge clk) begin
    sb_t e;
    logic [6:0] act;
    if (sb_q.size() != 0) begin
      e   = sb_q.pop_front();
      act = {imem_req, pc_sel, pc_en, ifid_en, ifid_flush, busy, fetch_err};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (req,sel,pc_en,ifid_en,flush,busy,err)",
                 e.name, act, e.exp);
      end
      checks++;
      if (ifid_en && ifid_flush) begin
        errors++;
        $display("FAIL %s_en_flush: got ifid_en=1 ifid_flush=1 expected not both", e.name);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; br_taken_M = 1'b0; stall_D = 1'b0; imem_ready = 1'b0;
    cyc(0, 0, 0, 1, 0, '0, "");
    cyc(0, 0, 0, 1, 0, '0, "");

    // Zero-wait stream: RST then 7 sequential fetches.
    cyc(1, 0, 0, 1, 1, O_RST, "zw_rst");
    for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1, 1, O_SEQ, "zw_seq");

    // Wait states twice in a row; counter must restart after each ready.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, O_WAIT, "ws_wait_a");
    cyc(1, 0, 0, 1, 1, O_SEQ, "ws_done_a");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, O_WAIT, "ws_wait_b");
    cyc(1, 0, 0, 1, 1, O_SEQ, "ws_done_b");

    // Decode stall holds IF/ID and PC.
    cyc(1, 0, 1, 1, 1, O_STALL, "stall_hold");
    cyc(1, 0, 1, 1, 1, O_STALL, "stall_hold2");
    cyc(1, 0, 0, 1, 1, O_SEQ, "stall_release");

    // Redirect while memory not ready: flush, abort, re-request.
    cyc(1, 1, 0, 0, 1, O_BR, "rd_br");
    cyc(1, 0, 0, 0, 1, O_ABRT, "rd_abort");
    cyc(1, 0, 0, 1, 1, O_SEQ, "rd_req");

    // Redirect while ready: no abort needed.
    cyc(1, 1, 0, 1, 1, O_BR, "rdy_br");
    cyc(1, 0, 0, 1, 1, O_SEQ, "rdy_br_next");

    // Back-to-back redirect holds ABORT one more cycle.
    cyc(1, 1, 0, 0, 1, O_BR, "ab_br");
    cyc(1, 1, 0, 0, 1, O_ABRB, "ab_br_again");
    cyc(1, 0, 0, 0, 1, O_ABRT, "ab_abort");
    cyc(1, 0, 0, 1, 1, O_SEQ, "ab_req");

    // Branch together with stall: flush wins, stays in REQ.
    cyc(1, 1, 1, 1, 1, O_BR, "brst_br");
    cyc(1, 0, 0, 1, 1, O_SEQ, "brst_next");

    // Redirect clears a partial wait count.
    cyc(1, 0, 0, 0, 1, O_WAIT, "rc_wait");
    cyc(1, 0, 0, 0, 1, O_WAIT, "rc_wait");
    cyc(1, 1, 0, 0, 1, O_BR, "rc_br");
    cyc(1, 0, 0, 0, 1, O_ABRT, "rc_abort");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, O_WAIT, "rc_wait_after");
    cyc(1, 0, 0, 1, 1, O_SEQ, "rc_done");

    // Timeout: 4 waiting REQ cycles, then sticky error ignoring branches.
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, O_WAIT, "to_wait");
    cyc(1, 0, 0, 0, 1, O_ERR, "to_err");
    cyc(1, 1, 0, 0, 1, O_ERR, "to_err_br");
    cyc(1, 0, 0, 1, 1, O_ERR, "to_err_rdy");
    cyc(1, 1, 0, 1, 1, O_ERR, "to_err_br2");

    // Reset out of ERR; branch in RST is ignored (next is REQ, not ABORT).
    cyc(0, 0, 0, 0, 0, '0, "");
    cyc(1, 1, 0, 0, 1, O_RST, "rs_rst_br");
    cyc(1, 0, 0, 1, 1, O_SEQ, "rs_req");

    // Reset mid-wait at count 2; full timeout needed afterwards.
    cyc(1, 0, 0, 0, 1, O_WAIT, "rw_wait");
    cyc(1, 0, 0, 0, 1, O_WAIT, "rw_wait");
    cyc(0, 0, 0, 0, 0, '0, "");
    cyc(1, 0, 0, 0, 1, O_RST, "rw_rst");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1, O_WAIT, "rw_full_wait");
    cyc(1, 0, 0, 0, 1, O_ERR, "rw_err");

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
